// File: rtl/matvec_stream_bridge_if.sv
// matvec_stream_bridge_if
// Bundles every handshake and bus signal of the matvec stream bridge.
//   s_*      : narrow operand input stream (valid/ready, one W-bit word per beat)
//   acc_i_*  : accelerator input handshake, bridge is the initiator
//   mat_r_c  : 16 parallel matrix operands, row-major
//   vec_k    : 4 parallel vector operands
//   acc_o_*  : accelerator output handshake, bridge is the receiver
//   prod_k   : 4 accelerator products
//   m_*      : result output stream (valid/ready/data/last)
//   err      : sticky accelerator timeout flag
// Modports: master = bridge side, slave = system/accelerator side.
interface matvec_stream_bridge_if #(
   parameter int unsigned W = 16
);
   logic         s_valid;
   logic         s_ready;
   logic [W-1:0] s_data;

   logic         acc_i_valid;
   logic         acc_i_ready;
   logic [W-1:0] mat_0_0, mat_0_1, mat_0_2, mat_0_3;
   logic [W-1:0] mat_1_0, mat_1_1, mat_1_2, mat_1_3;
   logic [W-1:0] mat_2_0, mat_2_1, mat_2_2, mat_2_3;
   logic [W-1:0] mat_3_0, mat_3_1, mat_3_2, mat_3_3;
   logic [W-1:0] vec_0, vec_1, vec_2, vec_3;

   logic         acc_o_valid;
   logic         acc_o_ready;
   logic [W-1:0] prod_0, prod_1, prod_2, prod_3;

   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] m_data;
   logic         m_last;

   logic         err;

   modport master (
      input  s_valid, s_data,
      output s_ready,
      output acc_i_valid,
      input  acc_i_ready,
      output mat_0_0, mat_0_1, mat_0_2, mat_0_3,
      output mat_1_0, mat_1_1, mat_1_2, mat_1_3,
      output mat_2_0, mat_2_1, mat_2_2, mat_2_3,
      output mat_3_0, mat_3_1, mat_3_2, mat_3_3,
      output vec_0, vec_1, vec_2, vec_3,
      input  acc_o_valid,
      output acc_o_ready,
      input  prod_0, prod_1, prod_2, prod_3,
      output m_valid, m_data, m_last,
      input  m_ready,
      output err
   );

   modport slave (
      output s_valid, s_data,
      input  s_ready,
      input  acc_i_valid,
      output acc_i_ready,
      input  mat_0_0, mat_0_1, mat_0_2, mat_0_3,
      input  mat_1_0, mat_1_1, mat_1_2, mat_1_3,
      input  mat_2_0, mat_2_1, mat_2_2, mat_2_3,
      input  mat_3_0, mat_3_1, mat_3_2, mat_3_3,
      input  vec_0, vec_1, vec_2, vec_3,
      output acc_o_valid,
      input  acc_o_ready,
      output prod_0, prod_1, prod_2, prod_3,
      input  m_valid, m_data, m_last,
      output m_ready,
      input  err
   );
endinterface

// File: rtl/matvec_stream_bridge.sv
// matvec_stream_bridge
// Host-side initiator for the 4x4 matrix-vector accelerator. Collects a 20-word operand
// packet (16 matrix words row-major, then 4 vector words), presents it in parallel, issues
// the accelerator input handshake, captures the 4 products and streams them out as a 4-word
// packet with m_last on the final word.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : matvec_stream_bridge_if.master (operand stream, accelerator buses, result stream,
//          err flag)
// Parameters:
//   W       : word width (opaque data, no arithmetic performed)
//   TIMEOUT : accelerator wait limit in cycles (only used with MATVEC_BRIDGE_TIMEOUT_EN)
// Build option:
//   MATVEC_BRIDGE_TIMEOUT_EN : when defined, a silent accelerator is abandoned after TIMEOUT
//   S_WAIT cycles; err sets (sticky) and four all-ones words are drained instead. When not
//   defined, S_WAIT waits indefinitely and err is tied 0.
module matvec_stream_bridge #(
   parameter int unsigned W       = 16,
   parameter int unsigned TIMEOUT = 256
) (
   input logic                    clk,
   input logic                    rst,
   matvec_stream_bridge_if.master bus
);

   localparam int unsigned NumOps   = 20;
   localparam logic [4:0]  LastWord = 5'd19;

   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {StLoad, StIssue, StWait, StDrain} state_e;

   state_e       state_q;
   logic [4:0]   load_cnt_q;
   logic [1:0]   drain_cnt_q;
   logic [W-1:0] ops_q [NumOps];
   logic [W-1:0] res_q [4];
   logic         s_ready_q;
   logic         acc_i_valid_q;
   logic         acc_o_ready_q;
   logic         m_valid_q;
   logic         m_last_q;
   logic [W-1:0] m_data_q;

`ifdef MATVEC_BRIDGE_TIMEOUT_EN
   localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
   logic [WaitW-1:0] wait_cnt_q;
   logic             err_q;
`endif

   // Handshake outputs are registered from the next state, so each phase's output is
   // already valid in the first cycle of that phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StLoad;
         load_cnt_q    <= '0;
         drain_cnt_q   <= '0;
         s_ready_q     <= 1'b0;
         acc_i_valid_q <= 1'b0;
         acc_o_ready_q <= 1'b0;
         m_valid_q     <= 1'b0;
         m_last_q      <= 1'b0;
         m_data_q      <= '0;
         for (int i = 0; i < int'(NumOps); i++) ops_q[i] <= '0;
         for (int i = 0; i < 4; i++) res_q[i] <= '0;
`ifdef MATVEC_BRIDGE_TIMEOUT_EN
         wait_cnt_q    <= '0;
         err_q         <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StLoad: begin
               // Covers the first cycle after reset, where s_ready is still low.
               s_ready_q <= 1'b1;
               if (bus.s_valid && s_ready_q) begin
                  ops_q[load_cnt_q] <= bus.s_data;
                  if (load_cnt_q == LastWord) begin
                     load_cnt_q    <= '0;
                     state_q       <= StIssue;
                     s_ready_q     <= 1'b0;
                     acc_i_valid_q <= 1'b1;
                  end else begin
                     load_cnt_q <= load_cnt_q + 5'd1;
                  end
               end
            end
            StIssue: begin
               if (bus.acc_i_ready) begin
                  state_q       <= StWait;
                  acc_i_valid_q <= 1'b0;
                  acc_o_ready_q <= 1'b1;
`ifdef MATVEC_BRIDGE_TIMEOUT_EN
                  wait_cnt_q    <= '0;
`endif
               end
            end
            StWait: begin
               if (bus.acc_o_valid) begin
                  res_q[0]      <= bus.prod_0;
                  res_q[1]      <= bus.prod_1;
                  res_q[2]      <= bus.prod_2;
                  res_q[3]      <= bus.prod_3;
                  m_data_q      <= bus.prod_0;
                  state_q       <= StDrain;
                  acc_o_ready_q <= 1'b0;
                  m_valid_q     <= 1'b1;
                  m_last_q      <= 1'b0;
`ifdef MATVEC_BRIDGE_TIMEOUT_EN
               end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
                  // This is the TIMEOUT-th silent cycle: give up and drain all-ones.
                  for (int i = 0; i < 4; i++) res_q[i] <= {W{1'b1}};
                  m_data_q      <= {W{1'b1}};
                  err_q         <= 1'b1;
                  state_q       <= StDrain;
                  acc_o_ready_q <= 1'b0;
                  m_valid_q     <= 1'b1;
                  m_last_q      <= 1'b0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
               end
            end
            StDrain: begin
               if (bus.m_ready) begin
                  if (drain_cnt_q == 2'd3) begin
                     drain_cnt_q <= '0;
                     state_q     <= StLoad;
                     m_valid_q   <= 1'b0;
                     m_last_q    <= 1'b0;
                     s_ready_q   <= 1'b1;
                  end else begin
                     drain_cnt_q <= drain_cnt_q + 2'd1;
                     m_data_q    <= res_q[drain_cnt_q + 2'd1];
                     m_last_q    <= (drain_cnt_q == 2'd2);
                  end
               end
            end
            default: state_q <= StLoad;
         endcase
      end
   end

   assign bus.s_ready     = s_ready_q;
   assign bus.acc_i_valid = acc_i_valid_q;
   assign bus.acc_o_ready = acc_o_ready_q;
   assign bus.m_valid     = m_valid_q;
   assign bus.m_last      = m_last_q;
   assign bus.m_data      = m_data_q;

   assign bus.mat_0_0 = ops_q[0];
   assign bus.mat_0_1 = ops_q[1];
   assign bus.mat_0_2 = ops_q[2];
   assign bus.mat_0_3 = ops_q[3];
   assign bus.mat_1_0 = ops_q[4];
   assign bus.mat_1_1 = ops_q[5];
   assign bus.mat_1_2 = ops_q[6];
   assign bus.mat_1_3 = ops_q[7];
   assign bus.mat_2_0 = ops_q[8];
   assign bus.mat_2_1 = ops_q[9];
   assign bus.mat_2_2 = ops_q[10];
   assign bus.mat_2_3 = ops_q[11];
   assign bus.mat_3_0 = ops_q[12];
   assign bus.mat_3_1 = ops_q[13];
   assign bus.mat_3_2 = ops_q[14];
   assign bus.mat_3_3 = ops_q[15];
   assign bus.vec_0   = ops_q[16];
   assign bus.vec_1   = ops_q[17];
   assign bus.vec_2   = ops_q[18];
   assign bus.vec_3   = ops_q[19];

`ifdef MATVEC_BRIDGE_TIMEOUT_EN
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_matvec_stream_bridge.sv
// tb_matvec_stream_bridge
// Directed scenarios followed by randomized traffic. A transaction-level model tracks how
// many words, issues, captures and result beats the bridge must have done, and from that
// derives every output each cycle.
module tb_matvec_stream_bridge;

   localparam int unsigned W          = 16;
   localparam int unsigned TB_TIMEOUT = 8;
`ifdef MATVEC_BRIDGE_TIMEOUT_EN
   localparam int COMPUTE = 5;
`else
   localparam int COMPUTE = 17;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   matvec_stream_bridge_if #(.W(W)) bus ();

   matvec_stream_bridge #(
      .W       (W),
      .TIMEOUT (TB_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   wire [20*W-1:0] dut_ops = {bus.vec_3, bus.vec_2, bus.vec_1, bus.vec_0,
                              bus.mat_3_3, bus.mat_3_2, bus.mat_3_1, bus.mat_3_0,
                              bus.mat_2_3, bus.mat_2_2, bus.mat_2_1, bus.mat_2_0,
                              bus.mat_1_3, bus.mat_1_2, bus.mat_1_1, bus.mat_1_0,
                              bus.mat_0_3, bus.mat_0_2, bus.mat_0_1, bus.mat_0_0};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Transaction-level model
   logic [W-1:0] m_ops [20] = '{default: '0};
   logic [W-1:0] exp_q [$];
   int  words, issues, captures, beats, since, wait_cycles;
   bit  exp_err;
   bit  e_s, e_i, e_o, e_m;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_s_ready", bus.s_ready, 0);
         chk("rst_acc_i_valid", bus.acc_i_valid, 0);
         chk("rst_acc_o_ready", bus.acc_o_ready, 0);
         chk("rst_m_valid", bus.m_valid, 0);
         chk("rst_m_last", bus.m_last, 0);
         chk("rst_err", bus.err, 0);
         chk("rst_m_data", bus.m_data, 0);
         for (int n = 0; n < 20; n++) chk($sformatf("rst_operand_%0d", n), dut_ops[n*W +: W], 0);
         for (int n = 0; n < 20; n++) m_ops[n] = '0;
         exp_q.delete();
         words = 0; issues = 0; captures = 0; beats = 0; since = 0; wait_cycles = 0;
         exp_err = 1'b0;
      end else begin
         e_i = (words / 20) > issues;
         e_o = issues > captures;
         e_m = beats < captures * 4;
         e_s = !e_i && !e_o && !e_m && (since >= 1);
         chk("s_ready", bus.s_ready, e_s);
         chk("acc_i_valid", bus.acc_i_valid, e_i);
         chk("acc_o_ready", bus.acc_o_ready, e_o);
         chk("m_valid", bus.m_valid, e_m);
         chk("err", bus.err, exp_err);
         for (int n = 0; n < 20; n++) chk($sformatf("operand_%0d", n), dut_ops[n*W +: W], m_ops[n]);
         if (e_m) begin
            chk("m_data", bus.m_data, (exp_q.size() > 0) ? exp_q[0] : 'x);
            chk("m_last", bus.m_last, (beats % 4) == 3);
         end else begin
            chk("m_last_idle", bus.m_last, 0);
         end
         // Advance the model by the handshakes that complete at the coming edge.
         if (e_s && bus.s_valid) begin
            m_ops[words % 20] = bus.s_data;
            words++;
         end
         if (e_i && bus.acc_i_ready) begin
            issues++;
            wait_cycles = 0;
         end
         if (e_o) begin
            if (bus.acc_o_valid) begin
               exp_q.push_back(bus.prod_0);
               exp_q.push_back(bus.prod_1);
               exp_q.push_back(bus.prod_2);
               exp_q.push_back(bus.prod_3);
               captures++;
            end
`ifdef MATVEC_BRIDGE_TIMEOUT_EN
            else begin
               wait_cycles++;
               if (wait_cycles == int'(TB_TIMEOUT)) begin
                  for (int k = 0; k < 4; k++) exp_q.push_back({W{1'b1}});
                  captures++;
                  exp_err = 1'b1;
               end
            end
`endif
         end
         if (e_m && bus.m_ready) begin
            void'(exp_q.pop_front());
            beats++;
         end
         since++;
      end
   end

   // Directed helpers
   logic         pre_iv;
   logic [W-1:0] dw [4];
   logic         dl [4];
   int           got;
   logic [3:0]   pat = 4'b1001;

   task automatic send_word(input logic [W-1:0] d);
      bit ok = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge clk);
         if (bus.s_ready) begin
            ok     = 1'b1;
            pre_iv = bus.acc_i_valid;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) chk("s_ready_wait_expired", 0, 1);
   endtask

   task automatic wait_issue();
      bit ok = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge clk);
         if (bus.acc_i_valid && bus.acc_i_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("acc_i_handshake_wait_expired", 0, 1);
   endtask

   task automatic drain(input bit patterned);
      got = 0;
      for (int k = 0; k < 40 && got < 4; k++) begin
         bus.m_ready = patterned ? pat[k % 4] : 1'b1;
         @(negedge clk);
         if (bus.m_valid && bus.m_ready) begin
            dw[got] = bus.m_data;
            dl[got] = bus.m_last;
            got++;
         end
         @(posedge clk);
         #1;
      end
      bus.m_ready = 1'b0;
      chk("drain_word_count", got, 4);
   endtask

   initial begin
      bit ok;
      int cnt;
      bus.s_valid = 0; bus.s_data = '0; bus.acc_i_ready = 0; bus.acc_o_valid = 0;
      bus.prod_0 = '0; bus.prod_1 = '0; bus.prod_2 = '0; bus.prod_3 = '0; bus.m_ready = 0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("s_ready_first_cycle", bus.s_ready, 0);
      @(negedge clk);
      chk("s_ready_second_cycle", bus.s_ready, 1);
      @(posedge clk);
      #1;

      // Packet 0x0000..0x0013 back-to-back
      for (int i = 0; i < 20; i++) send_word(W'(i));
      bus.s_valid = 1'b0;
      chk("acc_i_valid_before_word19", pre_iv, 0);
      @(negedge clk);
      chk("acc_i_valid_after_word19", bus.acc_i_valid, 1);
      chk("mat_2_1", bus.mat_2_1, 'h0009);
      chk("vec_3", bus.vec_3, 'h0013);
      @(posedge clk);
      #1;

      // Accelerator not ready for 5 cycles, then one handshake
      repeat (4) @(posedge clk);
      #1 bus.acc_i_ready = 1'b1;
      wait_issue();
      bus.acc_i_ready = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = 'hBEEF;
      repeat (COMPUTE) @(posedge clk);
      #1;
      bus.prod_0 = 'h0A; bus.prod_1 = 'h0B; bus.prod_2 = 'h0C; bus.prod_3 = 'h0D;
      bus.acc_o_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge clk);
         if (bus.acc_o_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("acc_o_ready_wait_expired", 0, 1);
      bus.acc_o_valid = 1'b0;
      bus.s_valid = 1'b0;
      chk("beef_rejected_mat_0_0", bus.mat_0_0, 'h0000);
      chk("beef_rejected_vec_3", bus.vec_3, 'h0013);

      drain(1'b1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("result_word_%0d", i), dw[i], 'h0A + i);
         chk($sformatf("result_last_%0d", i), dl[i], i == 3);
      end
      @(negedge clk);
      chk("s_ready_after_drain", bus.s_ready, 1);
      @(posedge clk);
      #1;

`ifdef MATVEC_BRIDGE_TIMEOUT_EN
      // Silent accelerator
      bus.acc_i_ready = 1'b1;
      for (int i = 0; i < 20; i++) send_word(W'($urandom));
      bus.s_valid = 1'b0;
      wait_issue();
      bus.acc_i_ready = 1'b0;
      ok  = 1'b0;
      cnt = 0;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge clk);
         if (bus.err) ok = 1'b1;
         else if (bus.acc_o_ready) cnt++;
      end
      chk("timeout_err_set", ok, 1);
      chk("timeout_wait_cycles", cnt, TB_TIMEOUT);
      @(posedge clk);
      #1;
      drain(1'b0);
      for (int i = 0; i < 4; i++) chk($sformatf("timeout_word_%0d", i), dw[i], 'hFFFF);
      @(negedge clk);
      chk("s_ready_after_timeout", bus.s_ready, 1);
      @(posedge clk);
      #1 bus.acc_o_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.acc_o_valid = 1'b0;
`endif

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         bus.s_valid     = ($urandom_range(0, 3) != 0);
         bus.s_data      = W'($urandom);
         bus.acc_i_ready = ($urandom_range(0, 1) != 0);
         bus.acc_o_valid = ($urandom_range(0, 3) == 0);
         bus.prod_0      = W'($urandom);
         bus.prod_1      = W'($urandom);
         bus.prod_2      = W'($urandom);
         bus.prod_3      = W'($urandom);
         bus.m_ready     = ($urandom_range(0, 2) != 0);
         @(posedge clk);
         #1;
      end
      chk("random_packets_progressed", (beats >= 40), 1);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/matvec_stream_bridge.md
# matvec_stream_bridge

Host-side initiator for the 4x4 matrix-vector product accelerator. Collects a 20-word operand packet (16 matrix words row-major, then 4 vector words) from a narrow valid/ready input stream and presents it in parallel on the accelerator operand bus. It then issues the accelerator input handshake, captures the 4 products on the accelerator output handshake, and streams them back out as a 4-word packet. Sits between the system stream fabric and the accelerator; the accelerator is its only downstream responder.

## Interface
- `W`, 16, width of every matrix, vector and product word (opaque bits; the bridge performs no arithmetic on them).
- `TIMEOUT`, 256, accelerator wait limit in cycles; used only when the timeout feature is compiled in.

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `s_valid`, `s_ready`  in/out  1  operand stream handshake
- `s_data`  in  W  operand word
- `acc_i_valid`  out  1  to accelerator `i_valid`
- `acc_i_ready`  in  1  from accelerator `i_ready`
- `mat_r_c` (r,c in 0..3)  out  W each  16 matrix operands
- `vec_k` (k in 0..3)  out  W each  vector operands
- `acc_o_valid`  in  1  from accelerator `o_valid`
- `acc_o_ready`  out  1  to accelerator `o_ready`
- `prod_k` (k in 0..3)  in  W each  accelerator products
- `m_valid`, `m_ready`  out/in  1  result stream handshake
- `m_data`  out  W  result word
- `m_last`  out  1  high on the 4th result word
- `err`  out  1  sticky timeout flag

## Operation
- States: S_LOAD, S_ISSUE, S_WAIT, S_DRAIN. Reset enters S_LOAD with `load_cnt`=0 and `drain_cnt`=0.
- S_LOAD: `s_ready`=1. Each `s_valid&s_ready` beat writes `s_data` to operand register `load_cnt`: 0..15 map to `mat_(n/4)_(n%4)`, 16..19 map to `vec_(n-16)`. Then `load_cnt` increments. On beat 19, `load_cnt` returns to 0 and the state moves to S_ISSUE.
- S_ISSUE: `acc_i_valid`=1. On `acc_i_valid&acc_i_ready` the state moves to S_WAIT.
- S_WAIT: `acc_o_ready`=1. On `acc_o_valid`, `prod_0..3` are latched into result registers and the state moves to S_DRAIN.
- S_DRAIN: `m_valid`=1, `m_data`=result[`drain_cnt`], `m_last`=(`drain_cnt`==3). Each `m_valid&m_ready` beat increments `drain_cnt`. The beat with `drain_cnt`=3 clears `drain_cnt` and returns the state to S_LOAD.
- Operand registers change only on S_LOAD beats. They are therefore stable from S_ISSUE until the next packet's first word, because the accelerator samples them throughout its compute.
- Result registers change only on the S_WAIT capture.
- `acc_o_valid` asserted outside S_WAIT is ignored; no capture occurs.
- `acc_i_ready` low in S_ISSUE stalls indefinitely; `acc_i_valid` is held high and never drops before the handshake.
- `s_ready`=0 outside S_LOAD. A new packet cannot begin until the previous result packet has fully drained.

## Timing
- All outputs are registered or decoded from registered state.
- While `rst` is high and on the first cycle after release, the following are 0: `s_ready`, `acc_i_valid`, `acc_o_ready`, `m_valid`, `m_last`, `err`.
- Reset values: `m_data`, operand registers and result registers are 0.
- Latencies:
  - 20th accepted word to `acc_i_valid` high: 1 cycle.
  - `acc_o_valid` capture to `m_valid` high: 1 cycle.
  - Last result beat to `s_ready` high: 1 cycle.
- Minimum packet time with no back-pressure, and an accelerator ready immediately with 17-cycle compute: 20 + 1 + 17 + 1 + 4 cycles.
- Reset mid-packet discards partial operands, any in-flight handshake and undrained results. Re-reset of the accelerator is the system's responsibility.

## Configuration
- `MATVEC_BRIDGE_TIMEOUT_EN` defined:
  - A wait counter clears on entering S_WAIT and increments each S_WAIT cycle.
  - When it reaches `TIMEOUT` without `acc_o_valid`, `err` sets (sticky until `rst`), all result registers load `{W{1'b1}}`, and the state moves to S_DRAIN.
  - A late `acc_o_valid` is then ignored until the next S_WAIT.
- Not defined: no counter exists, S_WAIT waits indefinitely, and `err` is tied 0.

## Test plan
- Reset hold 3 cycles -> all handshake outputs 0 during reset; `s_ready`=1 on the 2nd cycle after release.
- Words 0x0000..0x0013 streamed back-to-back -> `mat_2_1`=0x0009, `vec_3`=0x0013; `acc_i_valid` rises exactly 1 cycle after word 19.
- Model accelerator: `acc_i_ready` low 5 cycles, then high; `prod`=0x0A,0x0B,0x0C,0x0D after 17 cycles -> single `acc_i` handshake; output words 0x0A..0x0D in order with `m_last` only on 0x0D.
- `m_ready` toggled 1,0,0,1,... during drain -> `m_data` held stable while stalled; no word dropped or duplicated.
- `s_valid` asserted during S_WAIT with 0xBEEF -> not accepted; operand outputs unchanged.
- With `MATVEC_BRIDGE_TIMEOUT_EN`, `TIMEOUT`=8, accelerator silent -> `err`=1 after 8 S_WAIT cycles; four 0xFFFF words drained; `s_ready` returns.
